// File: rtl/carbon_boot_copier_if.sv
// Carbon fabric constants and the request/response interface.
// One request and one response channel, each with a valid/ready handshake.
package carbon_fabric_pkg;
    localparam int FAB_ADDR_W = 32;
    localparam int FAB_DATA_W = 32;
    localparam int FAB_CODE_W = 2;
    localparam int FAB_ID_W   = 4;
    localparam int FAB_ATTR_W = 4;
    localparam int FAB_OP_W   = 2;
    localparam int FAB_SIZE_W = 3;

    localparam logic [FAB_OP_W-1:0] CARBON_FABRIC_XACT_READ  = 2'd0;
    localparam logic [FAB_OP_W-1:0] CARBON_FABRIC_XACT_WRITE = 2'd1;

    localparam logic [FAB_CODE_W-1:0] CARBON_FABRIC_RESP_OK           = 2'd0;
    localparam logic [FAB_CODE_W-1:0] CARBON_FABRIC_RESP_DECODE_ERR   = 2'd1;
    localparam logic [FAB_CODE_W-1:0] CARBON_FABRIC_RESP_ACCESS_FAULT = 2'd2;
endpackage

interface fabric_if;
    import carbon_fabric_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [FAB_ADDR_W-1:0]   req_addr;
    logic [FAB_OP_W-1:0]     req_op;
    logic [FAB_SIZE_W-1:0]   req_size;
    logic [FAB_ATTR_W-1:0]   req_attr;
    logic [FAB_ID_W-1:0]     req_id;
    logic [FAB_DATA_W-1:0]   req_wdata;
    logic [FAB_DATA_W/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [FAB_DATA_W-1:0]   rsp_rdata;
    logic [FAB_CODE_W-1:0]   rsp_code;
    logic [FAB_ID_W-1:0]     rsp_id;

    modport master (
        output req_valid, req_addr, req_op, req_size, req_attr,
        output req_id, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_size, req_attr,
        input  req_id, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );
endinterface

// File: rtl/carbon_boot_copier.sv
// Boot-time ROM->RAM copier; keeps the CPU in reset until the image is in RAM.
// Define CARBON_BOOTCOPY_VERIFY_EN to read back and compare every written word.
module carbon_boot_copier
    import carbon_fabric_pkg::*;
#(
    parameter logic [31:0] SRC_ADDR   = 32'h0000_0000,
    parameter logic [31:0] DST_ADDR   = 32'h0001_0000,
    parameter int          COPY_BYTES = 256,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    fabric_if.master              bus,
    output logic                  cpu_rst_hold,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           err_addr,
    output logic [FAB_CODE_W-1:0] err_code
);
    localparam int W      = FAB_DATA_W;
    localparam int BPW    = W / 8;
    localparam int NWORDS = (COPY_BYTES + BPW - 1) / BPW;
    localparam int IW     = (NWORDS > 0) ? $clog2(NWORDS + 1) : 1;
    localparam int REM    = COPY_BYTES % BPW;

    localparam logic [BPW-1:0] FULL_STRB = '1;
    localparam logic [BPW-1:0] LAST_STRB =
        (REM != 0) ? BPW'((1 << REM) - 1) : FULL_STRB;

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
`ifdef CARBON_BOOTCOPY_VERIFY_EN
        VF_REQ,
        VF_RSP,
`endif
        DONE,
        ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [W-1:0]          wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [FAB_CODE_W-1:0] err_code_q, err_code_d;

    logic [31:0]           offs;
    logic [31:0]           cur_addr;
    logic [BPW-1:0]        cur_strb;
    logic                  is_last;
    logic                  rsp_bad;
    logic                  fail;
    logic                  adv;
    logic [FAB_CODE_W-1:0] fail_code;

    assign offs     = 32'(idx_q) << $clog2(BPW);
    assign is_last  = (32'(idx_q) == 32'(NWORDS - 1));
    assign cur_strb = is_last ? LAST_STRB : FULL_STRB;
    assign cur_addr = (state_q == RD_REQ || state_q == RD_RSP)
                    ? SRC_ADDR + offs : DST_ADDR + offs;
    // A foreign response id is handled exactly like a bad response code.
    assign rsp_bad  = (bus.rsp_code != CARBON_FABRIC_RESP_OK)
                   || (bus.rsp_id != '0);

`ifdef CARBON_BOOTCOPY_VERIFY_EN
    logic [W-1:0] vf_mask;
    logic         vf_mismatch;

    always_comb begin
        vf_mask = '0;
        for (int b = 0; b < BPW; b++) begin
            vf_mask[8*b +: 8] = {8{cur_strb[b]}};
        end
    end

    assign vf_mismatch = |((bus.rsp_rdata ^ wdata_q) & vf_mask);
`endif

    always_comb begin
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_addr  = cur_addr;
        bus.req_op    = CARBON_FABRIC_XACT_READ;
        bus.req_size  = FAB_SIZE_W'($clog2(BPW));
        bus.req_attr  = '0;
        bus.req_id    = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        unique case (state_q)
            IDLE:   bus.rsp_ready = 1'b1;
            RD_REQ: bus.req_valid = 1'b1;
            RD_RSP: bus.rsp_ready = 1'b1;
            WR_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_op    = CARBON_FABRIC_XACT_WRITE;
                bus.req_wdata = wdata_q;
                bus.req_wstrb = cur_strb;
            end
            WR_RSP: bus.rsp_ready = 1'b1;
`ifdef CARBON_BOOTCOPY_VERIFY_EN
            VF_REQ: bus.req_valid = 1'b1;
            VF_RSP: bus.rsp_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = bus.rsp_code;
        adv        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (AUTO_START || start) begin
                    if (NWORDS == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: if (bus.req_ready) state_d = RD_RSP;
            RD_RSP: begin
                if (bus.rsp_valid) begin
                    if (rsp_bad) begin
                        fail = 1'b1;
                    end else begin
                        wdata_d = bus.rsp_rdata;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: if (bus.req_ready) state_d = WR_RSP;
            WR_RSP: begin
                if (bus.rsp_valid) begin
                    if (rsp_bad) begin
                        fail = 1'b1;
                    end else begin
`ifdef CARBON_BOOTCOPY_VERIFY_EN
                        state_d = VF_REQ;
`else
                        adv = 1'b1;
`endif
                    end
                end
            end
`ifdef CARBON_BOOTCOPY_VERIFY_EN
            VF_REQ: if (bus.req_ready) state_d = VF_RSP;
            VF_RSP: begin
                if (bus.rsp_valid) begin
                    if (rsp_bad) begin
                        fail = 1'b1;
                    end else if (vf_mismatch) begin
                        fail      = 1'b1;
                        fail_code = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
        if (fail) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_addr_d = cur_addr;
            err_code_d = fail_code;
        end
        if (adv) begin
            idx_d = idx_q + IW'(1);
            if (is_last) begin
                state_d = DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
            end else begin
                state_d = RD_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            err_code_q <= err_code_d;
        end
    end

    assign cpu_rst_hold = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_addr     = err_addr_q;
    assign err_code     = err_code_q;
endmodule

// File: tb/tb_carbon_boot_copier.sv
// Bench: two copiers (16 B manual start, 6 B auto start) on modelled ROM/RAM
// slaves; expected transaction lists come from plain word arithmetic.
module tb_carbon_boot_copier;
    import carbon_fabric_pkg::*;

    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic start0;
    logic start1;

    logic                  hold  [2];
    logic                  done  [2];
    logic                  err   [2];
    logic [31:0]           eaddr [2];
    logic [FAB_CODE_W-1:0] ecode [2];

    fabric_if b0 ();
    fabric_if b1 ();

    carbon_boot_copier #(
        .SRC_ADDR(SRC), .DST_ADDR(DST), .COPY_BYTES(16), .AUTO_START(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start0), .bus(b0),
        .cpu_rst_hold(hold[0]), .done(done[0]), .error(err[0]),
        .err_addr(eaddr[0]), .err_code(ecode[0])
    );

    carbon_boot_copier #(
        .SRC_ADDR(SRC), .DST_ADDR(DST), .COPY_BYTES(6), .AUTO_START(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start1), .bus(b1),
        .cpu_rst_hold(hold[1]), .done(done[1]), .error(err[1]),
        .err_addr(eaddr[1]), .err_code(ecode[1])
    );

    logic                  rv   [2];
    logic                  rr   [2];
    logic                  rspr [2];
    logic                  rspv [2];
    logic [31:0]           ra   [2];
    logic [FAB_OP_W-1:0]   rop  [2];
    logic [FAB_SIZE_W-1:0] rsz  [2];
    logic [FAB_ATTR_W-1:0] rat  [2];
    logic [FAB_ID_W-1:0]   rid  [2];
    logic [31:0]           rwd  [2];
    logic [3:0]            rws  [2];
    logic [31:0]           rdat [2];
    logic [FAB_CODE_W-1:0] rcode[2];

    assign rv[0]   = b0.req_valid;  assign rv[1]   = b1.req_valid;
    assign ra[0]   = b0.req_addr;   assign ra[1]   = b1.req_addr;
    assign rop[0]  = b0.req_op;     assign rop[1]  = b1.req_op;
    assign rsz[0]  = b0.req_size;   assign rsz[1]  = b1.req_size;
    assign rat[0]  = b0.req_attr;   assign rat[1]  = b1.req_attr;
    assign rid[0]  = b0.req_id;     assign rid[1]  = b1.req_id;
    assign rwd[0]  = b0.req_wdata;  assign rwd[1]  = b1.req_wdata;
    assign rws[0]  = b0.req_wstrb;  assign rws[1]  = b1.req_wstrb;
    assign rspr[0] = b0.rsp_ready;  assign rspr[1] = b1.rsp_ready;

    assign b0.req_ready = rr[0];    assign b1.req_ready = rr[1];
    assign b0.rsp_valid = rspv[0];  assign b1.rsp_valid = rspv[1];
    assign b0.rsp_rdata = rdat[0];  assign b1.rsp_rdata = rdat[1];
    assign b0.rsp_code  = rcode[0]; assign b1.rsp_code  = rcode[1];
    assign b0.rsp_id    = '0;       assign b1.rsp_id    = '0;

    // Slave configuration (written by the stimulus, read by the slave).
    int fault_wr  [2];
    int stall_wr  [2];
    int stall_len [2];
    int corrupt_w [2];

    int         wr_cnt    [2];
    int         stall_cnt [2];
    logic [7:0] ram       [2][256];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rr[i] = !(rv[i] && rop[i] == CARBON_FABRIC_XACT_WRITE
                      && wr_cnt[i] + 1 == stall_wr[i]
                      && stall_cnt[i] < stall_len[i]);
        end
    end

    // ROM byte at address a holds a[7:0]; RAM is a 256-byte window at DST.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                rspv[i]      <= 1'b0;
                rdat[i]      <= '0;
                rcode[i]     <= CARBON_FABRIC_RESP_OK;
                wr_cnt[i]    <= 0;
                stall_cnt[i] <= 0;
                for (int j = 0; j < 256; j++) ram[i][j] <= 8'hEE;
            end else begin
                if (rspv[i] && rspr[i]) rspv[i] <= 1'b0;
                if (rv[i] && !rr[i]) stall_cnt[i] <= stall_cnt[i] + 1;
                if (rv[i] && rr[i]) begin
                    rspv[i]  <= 1'b1;
                    rcode[i] <= CARBON_FABRIC_RESP_OK;
                    rdat[i]  <= '0;
                    if (rop[i] == CARBON_FABRIC_XACT_WRITE) begin
                        wr_cnt[i] <= wr_cnt[i] + 1;
                        if (wr_cnt[i] + 1 == fault_wr[i]) begin
                            rcode[i] <= CARBON_FABRIC_RESP_ACCESS_FAULT;
                        end else begin
                            for (int b = 0; b < 4; b++) begin
                                if (rws[i][b]) begin
                                    ram[i][8'(ra[i][7:0] + 8'(b))] <=
                                        (b == 0 && corrupt_w[i] == int'(ra[i][7:2]))
                                        ? ~rwd[i][7:0] : rwd[i][8*b +: 8];
                                end
                            end
                        end
                    end else if (ra[i] >= DST) begin
                        rdat[i] <= {ram[i][8'(ra[i][7:0] + 8'd3)],
                                    ram[i][8'(ra[i][7:0] + 8'd2)],
                                    ram[i][8'(ra[i][7:0] + 8'd1)],
                                    ram[i][ra[i][7:0]]};
                    end else begin
                        rdat[i] <= {8'(ra[i] + 32'd3), 8'(ra[i] + 32'd2),
                                    8'(ra[i] + 32'd1), ra[i][7:0]};
                    end
                end
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    logic [31:0]         ea [2][64];
    logic [31:0]         ew [2][64];
    logic [FAB_OP_W-1:0] eo [2][64];
    logic [3:0]          es [2][64];
    int                  en  [2];
    int                  ptr [2];
    logic                held [2];
    logic [31:0]         ha [2];
    logic [31:0]         hw [2];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [31:0] a,
                        input logic [FAB_OP_W-1:0] o,
                        input logic [31:0] d, input logic [3:0] s);
        ea[i][en[i]] = a;
        eo[i][en[i]] = o;
        ew[i][en[i]] = d;
        es[i][en[i]] = s;
        en[i]++;
    endtask

    // Expected request stream for a copy of nbytes, cut at a faulting write
    // (fw, 1-based) or at the verify read of a corrupted word (cw).
    task automatic build(input int i, input int nbytes, input int fw,
                         input int cw);
        int nw;
        logic [31:0] wd;
        logic [3:0] sb;
        nw = (nbytes + 3) / 4;
        en[i] = 0;
        ptr[i] = 0;
        fault_wr[i] = fw;
        corrupt_w[i] = cw;
        for (int w = 0; w < nw; w++) begin
            push(i, SRC + 32'(4 * w), CARBON_FABRIC_XACT_READ, 0, 0);
            wd = {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
            sb = (w == nw - 1 && nbytes % 4 != 0)
               ? 4'((1 << (nbytes % 4)) - 1) : 4'hF;
            push(i, DST + 32'(4 * w), CARBON_FABRIC_XACT_WRITE, wd, sb);
            if (w + 1 == fw) break;
`ifdef CARBON_BOOTCOPY_VERIFY_EN
            push(i, DST + 32'(4 * w), CARBON_FABRIC_XACT_READ, 0, 0);
            if (w == cw) break;
`endif
        end
    endtask

    task automatic mon();
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                held[i] = 1'b0;
            end else begin
                chk($sformatf("hold_rule%0d", i), 32'(hold[i]), 32'(!done[i]));
                if (rv[i] && !rr[i]) begin
                    if (held[i]) begin
                        chk($sformatf("stall_addr%0d", i), ra[i], ha[i]);
                        chk($sformatf("stall_wdata%0d", i), rwd[i], hw[i]);
                    end
                    held[i] = 1'b1;
                    ha[i] = ra[i];
                    hw[i] = rwd[i];
                end else begin
                    held[i] = 1'b0;
                end
                if (rv[i] && rr[i]) begin
                    if (ptr[i] >= en[i]) begin
                        checks++;
                        fails++;
                        $display("FAIL extra_req%0d got=%h exp=none", i, ra[i]);
                    end else begin
                        chk($sformatf("addr%0d_%0d", i, ptr[i]), ra[i], ea[i][ptr[i]]);
                        chk($sformatf("op%0d_%0d", i, ptr[i]), 32'(rop[i]), 32'(eo[i][ptr[i]]));
                        chk($sformatf("wdata%0d_%0d", i, ptr[i]), rwd[i], ew[i][ptr[i]]);
                        chk($sformatf("wstrb%0d_%0d", i, ptr[i]), 32'(rws[i]), 32'(es[i][ptr[i]]));
                        chk($sformatf("size%0d", i), 32'(rsz[i]), 32'd2);
                        chk($sformatf("attr_id%0d", i), 32'({rat[i], rid[i]}), 32'd0);
                        ptr[i]++;
                    end
                end
                if (done[i] || err[i]) begin
                    chk($sformatf("req_after_end%0d", i), 32'(rv[i]), 32'd0);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic run_to_end(input int i, input int budget);
        int n;
        n = 0;
        while (!(done[i] || err[i]) && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("finish_in_budget%0d", i), 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_start();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    function automatic logic [31:0] ramw(input int i, input int off);
        return {ram[i][off + 3], ram[i][off + 2], ram[i][off + 1], ram[i][off]};
    endfunction

    task automatic check_ram16(input string nm);
        chk({nm, "_w0"}, ramw(0, 0),  32'h0302_0100);
        chk({nm, "_w1"}, ramw(0, 4),  32'h0706_0504);
        chk({nm, "_w2"}, ramw(0, 8),  32'h0B0A_0908);
        chk({nm, "_w3"}, ramw(0, 12), 32'h0F0E_0D0C);
    endtask

    task automatic check_reset_state(input int i);
        chk($sformatf("rst_req_valid%0d", i), 32'(rv[i]), 32'd0);
        chk($sformatf("rst_rsp_ready%0d", i), 32'(rspr[i]), 32'd1);
        chk($sformatf("rst_hold%0d", i), 32'(hold[i]), 32'd1);
        chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
        chk($sformatf("rst_error%0d", i), 32'(err[i]), 32'd0);
        chk($sformatf("rst_err_addr%0d", i), eaddr[i], 32'd0);
        chk($sformatf("rst_err_code%0d", i), 32'(ecode[i]), 32'd0);
    endtask

    task automatic reset0();
        rst[0] = 1'b1;
        tick();
        tick();
        check_reset_state(0);
    endtask

    initial begin
        int n;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        held[0] = 1'b0;
        held[1] = 1'b0;
        stall_wr[0] = 0;  stall_wr[1] = 0;
        stall_len[0] = 0; stall_len[1] = 0;
        build(0, 16, 0, -1);
        build(1, 6, 0, -1);
        repeat (3) tick();
        check_reset_state(0);
        check_reset_state(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Instance 1 starts by itself; instance 0 waits for start.
        repeat (4) tick();
        chk("no_auto_start0", 32'(ptr[0] + int'(rv[0])), 32'd0);
        run_to_end(1, 200);
        chk("part_done", 32'(done[1]), 32'd1);
        chk("part_hold", 32'(hold[1]), 32'd0);
        chk("part_error", 32'(err[1]), 32'd0);
        chk("part_all_reqs", 32'(ptr[1]), 32'(en[1]));
        chk("part_writes", 32'(wr_cnt[1]), 32'd2);
        chk("part_w0", ramw(1, 0), 32'h0302_0100);
        chk("part_w1", ramw(1, 4), 32'hEEEE_0504);

        // Full copy with a 5-cycle stall on the second write.
        stall_wr[0] = 2;
        stall_len[0] = 5;
        pulse_start();
        run_to_end(0, 400);
        chk("full_done", 32'(done[0]), 32'd1);
        chk("full_hold", 32'(hold[0]), 32'd0);
        chk("full_error", 32'(err[0]), 32'd0);
        chk("full_all_reqs", 32'(ptr[0]), 32'(en[0]));
        chk("full_stall_cycles", 32'(stall_cnt[0]), 32'd5);
        check_ram16("full");
        pulse_start();
        repeat (3) tick();
        chk("start_ignored_in_done", 32'(ptr[0]), 32'(en[0]));

        // Access fault on the third write.
        reset0();
        stall_wr[0] = 0;
        build(0, 16, 3, -1);
        rst[0] = 1'b0;
        pulse_start();
        run_to_end(0, 400);
        repeat (10) tick();
        chk("fault_error", 32'(err[0]), 32'd1);
        chk("fault_done", 32'(done[0]), 32'd0);
        chk("fault_hold", 32'(hold[0]), 32'd1);
        chk("fault_err_addr", eaddr[0], 32'h0001_0008);
        chk("fault_err_code", 32'(ecode[0]), 32'(CARBON_FABRIC_RESP_ACCESS_FAULT));
        chk("fault_all_reqs", 32'(ptr[0]), 32'(en[0]));

        // Reset while a write request is pending, then restart.
        reset0();
        build(0, 16, 0, -1);
        stall_wr[0] = 2;
        stall_len[0] = 1000;
        rst[0] = 1'b0;
        pulse_start();
        n = 0;
        while (!(rv[0] && !rr[0] && rop[0] == CARBON_FABRIC_XACT_WRITE)
               && n < 100) begin
            tick();
            n++;
        end
        chk("reach_wr_req", 32'(n < 100), 32'd1);
        rst[0] = 1'b1;
        tick();
        check_reset_state(0);
        stall_wr[0] = 0;
        build(0, 16, 0, -1);
        rst[0] = 1'b0;
        repeat (3) tick();
        chk("idle_after_rst", 32'(ptr[0] + int'(rv[0])), 32'd0);
        pulse_start();
        run_to_end(0, 400);
        chk("restart_done", 32'(done[0]), 32'd1);
        chk("restart_all_reqs", 32'(ptr[0]), 32'(en[0]));
        check_ram16("restart");

`ifdef CARBON_BOOTCOPY_VERIFY_EN
        // RAM corrupts byte 0 of word 1; read-back must catch it.
        reset0();
        build(0, 16, 0, 1);
        rst[0] = 1'b0;
        pulse_start();
        run_to_end(0, 400);
        repeat (5) tick();
        chk("vf_error", 32'(err[0]), 32'd1);
        chk("vf_err_addr", eaddr[0], 32'h0001_0004);
        chk("vf_err_code", 32'(ecode[0]), 32'd0);
        chk("vf_all_reqs", 32'(ptr[0]), 32'(en[0]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
